// File: rtl/swap_ctrl.sv
// swap_ctrl: arbitrated two-requester controller that swaps one word between two memories
module swap_ctrl #(
   parameter int DW = 8,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req0,
   input  logic          req1,
   input  logic [AW-1:0] addra0,
   input  logic [AW-1:0] addra1,
   input  logic [AW-1:0] addrb0,
   input  logic [AW-1:0] addrb1,
   output logic [1:0]    gnt,
   output logic [1:0]    done,
   output logic          busy,
   input  logic          wr_en,
   input  logic          wr_sel,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   output logic          wr_err,
   input  logic          rd_sel,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data,
   output logic [7:0]    swap_cnt
);
   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
   state_t        state_q;
   logic [DW-1:0] mema [2**AW];
   logic [DW-1:0] memb [2**AW];
   logic [AW-1:0] aa_q, ab_q;
   logic [DW-1:0] ha_q, hb_q, rd_data_q;
   logic [1:0]    gnt_q, done_q;
   logic [7:0]    swap_cnt_q;
   logic          sel_q, prio_q, wr_err_q;
   logic          pick_d, go_d;
   // round-robin pick: on contention take the requester not granted last; preload writes win over requests
   always_comb begin
      pick_d = (req0 & req1) ? prio_q : req1;
      go_d   = !wr_en & (req0 | req1);
   end
   // FSM with registered grant/done pulses, error flag, read port and swap counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         gnt_q      <= '0;
         done_q     <= '0;
         wr_err_q   <= 1'b0;
         rd_data_q  <= '0;
         swap_cnt_q <= '0;
         prio_q     <= 1'b0;
         sel_q      <= 1'b0;
         aa_q       <= '0;
         ab_q       <= '0;
         ha_q       <= '0;
         hb_q       <= '0;
      end else begin
         gnt_q     <= '0;
         done_q    <= '0;
         wr_err_q  <= wr_en && (state_q != IDLE);
         rd_data_q <= rd_sel ? memb[rd_addr] : mema[rd_addr];
         case (state_q)
            IDLE: if (go_d) begin
               state_q <= READ;
               gnt_q   <= pick_d ? 2'b10 : 2'b01;
               sel_q   <= pick_d;
               prio_q  <= ~pick_d;
               aa_q    <= pick_d ? addra1 : addra0;
               ab_q    <= pick_d ? addrb1 : addrb0;
            end
            READ: begin
               ha_q    <= mema[aa_q];
               hb_q    <= memb[ab_q];
               state_q <= WRITE;
            end
            WRITE: state_q <= DONE;
            default: begin
               done_q     <= sel_q ? 2'b10 : 2'b01;
               swap_cnt_q <= swap_cnt_q + 8'd1;
               state_q    <= IDLE;
            end
         endcase
      end
   end
   // memories are not reset: preload writes in IDLE, cross-write of held words in WRITE
   always_ff @(posedge clk) begin
      if (state_q == IDLE && wr_en) begin
         if (wr_sel) memb[wr_addr] <= wr_data;
         else mema[wr_addr] <= wr_data;
      end else if (state_q == WRITE) begin
         mema[aa_q] <= hb_q;
         memb[ab_q] <= ha_q;
      end
   end
   assign gnt      = gnt_q;
   assign done     = done_q;
   assign busy     = state_q != IDLE;
   assign wr_err   = wr_err_q;
   assign rd_data  = rd_data_q;
   assign swap_cnt = swap_cnt_q;
endmodule

// File: tb/tb_swap_ctrl.sv
// tb_swap_ctrl: directed self-checking bench for swap_ctrl
module tb_swap_ctrl;
   logic       clk = 1'b0, rst = 1'b1;
   logic       req0 = 1'b0, req1 = 1'b0;
   logic [3:0] addra0 = '0, addra1 = '0, addrb0 = '0, addrb1 = '0;
   logic [1:0] gnt, done;
   logic       busy, wr_err;
   logic       wr_en = 1'b0, wr_sel = 1'b0, rd_sel = 1'b0;
   logic [3:0] wr_addr = '0, rd_addr = '0;
   logic [7:0] wr_data = '0, rd_data, swap_cnt;
   int n_pass = 0, n_tot = 0;
   logic [7:0] ma3, mb5;

   swap_ctrl #(.DW(8), .AW(4)) dut (
      .clk(clk), .rst(rst), .req0(req0), .req1(req1),
      .addra0(addra0), .addra1(addra1), .addrb0(addrb0), .addrb1(addrb1),
      .gnt(gnt), .done(done), .busy(busy),
      .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err),
      .rd_sel(rd_sel), .rd_addr(rd_addr), .rd_data(rd_data), .swap_cnt(swap_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_tot++;
      assert (obs === exp_v) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
   endtask

   task automatic wr(input logic s, input logic [3:0] a, input logic [7:0] d);
      wr_en = 1'b1; wr_sel = s; wr_addr = a; wr_data = d;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic chk_mem(input string tag, input logic s, input logic [3:0] a, input logic [7:0] exp_v);
      rd_sel = s; rd_addr = a;
      tick();
      chk(tag, rd_data, exp_v);
   endtask

   task automatic do_swap(input logic r, input logic [3:0] a, input logic [3:0] b);
      logic [1:0] e;
      e = r ? 2'b10 : 2'b01;
      if (r) begin req1 = 1'b1; addra1 = a; addrb1 = b; end
      else begin req0 = 1'b1; addra0 = a; addrb0 = b; end
      tick();
      chk("gnt", gnt, e);
      chk("busy_read", busy, 1);
      req0 = 1'b0; req1 = 1'b0;
      tick();
      chk("gnt_pulse", gnt, 0);
      tick();
      chk("done_early", done, 0);
      tick();
      chk("done", done, e);
      chk("busy_idle", busy, 0);
   endtask

   initial begin
      tick(); tick();
      chk("rst_gnt", gnt, 0);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_wr_err", wr_err, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_cnt", swap_cnt, 0);
      rst = 1'b0;
      // basic swap
      wr(1'b0, 4'd3, 8'hAA);
      wr(1'b1, 4'd5, 8'h55);
      do_swap(1'b0, 4'd3, 4'd5);
      chk("cnt1", swap_cnt, 1);
      chk_mem("mema3_swapped", 1'b0, 4'd3, 8'h55);
      chk_mem("memb5_swapped", 1'b1, 4'd5, 8'hAA);
      // same addresses twice restores the data
      wr(1'b0, 4'd0, 8'h11);
      wr(1'b1, 4'd0, 8'h22);
      do_swap(1'b0, 4'd0, 4'd0);
      chk_mem("mema0_once", 1'b0, 4'd0, 8'h22);
      do_swap(1'b0, 4'd0, 4'd0);
      chk_mem("mema0_twice", 1'b0, 4'd0, 8'h11);
      chk_mem("memb0_twice", 1'b1, 4'd0, 8'h22);
      chk("cnt3", swap_cnt, 3);
      // round robin from reset with both requesting
      rst = 1'b1;
      tick();
      chk("rst_cnt2", swap_cnt, 0);
      rst = 1'b0;
      chk_mem("persist_mema3", 1'b0, 4'd3, 8'h55);
      req0 = 1'b1; req1 = 1'b1;
      addra0 = 4'd1; addrb0 = 4'd1; addra1 = 4'd2; addrb1 = 4'd2;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("rr_gnt", gnt, (i % 2) ? 2'b10 : 2'b01);
         tick(); tick(); tick();
         chk("rr_done", done, (i % 2) ? 2'b10 : 2'b01);
      end
      req0 = 1'b0; req1 = 1'b0;
      chk("cnt4", swap_cnt, 4);
      // write while busy is dropped
      wr(1'b0, 4'd4, 8'h44);
      req0 = 1'b1; addra0 = 4'd0; addrb0 = 4'd0;
      tick();
      chk("busy_gnt", gnt, 2'b01);
      req0 = 1'b0;
      wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd3; wr_data = 8'hEE;
      tick();
      chk("wr_err_pulse", wr_err, 1);
      wr_en = 1'b0;
      tick();
      chk("wr_err_clear", wr_err, 0);
      tick();
      chk("busy_done", done, 2'b01);
      chk_mem("dropped_wr", 1'b0, 4'd3, 8'h55);
      chk_mem("mema0_swap5", 1'b0, 4'd0, 8'h22);
      chk("cnt5", swap_cnt, 5);
      // write wins over a simultaneous request
      wr_en = 1'b1; wr_sel = 1'b1; wr_addr = 4'd7; wr_data = 8'h77;
      req1 = 1'b1; addra1 = 4'd4; addrb1 = 4'd7;
      tick();
      chk("wr_win_gnt", gnt, 0);
      chk("wr_win_busy", busy, 0);
      chk("wr_win_err", wr_err, 0);
      wr_en = 1'b0;
      tick();
      chk("late_gnt", gnt, 2'b10);
      req1 = 1'b0;
      tick(); tick(); tick();
      chk("late_done", done, 2'b10);
      chk_mem("mema4", 1'b0, 4'd4, 8'h77);
      chk_mem("memb7", 1'b1, 4'd7, 8'h44);
      chk("cnt6", swap_cnt, 6);
      // reset in the WRITE cycle aborts the swap
      req0 = 1'b1; addra0 = 4'd3; addrb0 = 4'd5;
      tick();
      chk("abort_gnt", gnt, 2'b01);
      req0 = 1'b0;
      tick();
      chk("abort_in_write", busy, 1);
      #2 rst = 1'b1;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_cnt", swap_cnt, 0);
      tick();
      rst = 1'b0;
      chk("abort_no_done", done, 0);
      chk_mem("abort_mema3", 1'b0, 4'd3, 8'h55);
      chk_mem("abort_memb5", 1'b1, 4'd5, 8'hAA);
      req0 = 1'b1; req1 = 1'b1;
      addra0 = 4'd9; addrb0 = 4'd9; addra1 = 4'd9; addrb1 = 4'd9;
      tick();
      chk("post_rst_gnt", gnt, 2'b01);
      req0 = 1'b0; req1 = 1'b0;
      tick(); tick(); tick();
      chk("post_rst_done", done, 2'b01);
      chk("post_rst_cnt", swap_cnt, 1);
      // counter wrap and read port tracking memb[5]
      ma3 = 8'h55; mb5 = 8'hAA;
      rd_sel = 1'b1; rd_addr = 4'd5;
      req0 = 1'b1; addra0 = 4'd3; addrb0 = 4'd5;
      for (int i = 0; i < 255; i++) begin
         tick();
         chk("wrap_gnt", gnt, 2'b01);
         tick(); tick();
         chk("rd_old", rd_data, mb5);
         tick();
         {ma3, mb5} = {mb5, ma3};
         chk("rd_new", rd_data, mb5);
         chk("wrap_done", done, 2'b01);
         if (i == 253) chk("cnt255", swap_cnt, 255);
      end
      req0 = 1'b0;
      chk("cnt_wrap", swap_cnt, 0);
      chk_mem("final_mema3", 1'b0, 4'd3, ma3);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule

// File: doc/swap_ctrl.md
SWAP_CTRL -- requirements
Module: swap_ctrl

Interface
REQ-001 SHALL have parameters: DW, 8, memory data width; AW, 4, address width (depth 2**AW).
REQ-002 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-003 SHALL have ports: rst  in  1  asynchronous active-high reset.
REQ-004 SHALL have ports: req0/req1  in  1 each  swap request from requester 0/1; held until granted.
REQ-005 SHALL have ports: addra0/addra1  in  AW each  mema address of requester 0/1.
REQ-006 SHALL have ports: addrb0/addrb1  in  AW each  memb address of requester 0/1.
REQ-007 SHALL have ports: gnt  out  2  one-hot grant pulse, bit i for requester i.
REQ-008 SHALL have ports: done  out  2  one-hot completion pulse, bit i for requester i.
REQ-009 SHALL have ports: busy  out  1  high whenever FSM is not IDLE.
REQ-010 SHALL have ports: wr_en  in  1, wr_sel  in  1 (0=mema, 1=memb), wr_addr  in  AW, wr_data  in  DW  preload write port.
REQ-011 SHALL have ports: wr_err  out  1  pulse when wr_en is dropped.
REQ-012 SHALL have ports: rd_sel  in  1 (0=mema, 1=memb), rd_addr  in  AW, rd_data  out  DW  registered read port.
REQ-013 SHALL have ports: swap_cnt  out  8  count of completed swaps.

Function
REQ-014 SHALL contain two internal memories mema and memb, each 2**AW x DW, not reset.
REQ-015 SHALL implement FSM states IDLE, READ, WRITE, DONE; transitions READ->WRITE->DONE->IDLE are unconditional.
REQ-016 In IDLE with wr_en=1, SHALL write wr_data to the selected memory at wr_addr, issue no grant, and stay in IDLE.
REQ-017 In IDLE with wr_en=0 and any req, SHALL grant one requester, latch its addra/addrb, pulse gnt for 1 cycle (registered, same edge as entering READ), and go to READ.
REQ-018 Arbitration SHALL be round-robin: with both requesting, grant the one not granted last; after reset requester 0 has priority.
REQ-019 req SHALL be sampled only in IDLE; requests arriving while busy wait, with no loss.
REQ-020 In READ, SHALL capture mema[latched addra] and memb[latched addrb] into holding registers.
REQ-021 In WRITE, SHALL write held memb value to mema[addra] and held mema value to memb[addrb] in the same edge.
REQ-022 In DONE, SHALL pulse done bit of granted requester for 1 cycle and increment swap_cnt (mod 256, wraps 255->0).
REQ-023 Latency: gnt visible cycle N, done visible cycle N+3; next grant no earlier than N+4.
REQ-024 wr_en while busy SHALL be ignored (no memory change) and pulse wr_err the following cycle.
REQ-025 rd_data SHALL equal selected memory[rd_addr] sampled at previous edge; same-edge write returns old data.
REQ-026 rd port SHALL operate in every state, independent of FSM.
REQ-027 gnt and done SHALL never have more than one bit set; busy SHALL be 0 only in IDLE.

Reset
REQ-028 rst SHALL asynchronously force FSM=IDLE, gnt=0, done=0, busy=0, wr_err=0, rd_data=0, swap_cnt=0, round-robin pointer to requester 0.
REQ-029 rst mid-swap SHALL abort without done pulse; memory contents are those written before the reset edge.
REQ-030 Memory contents SHALL persist across rst.

Verification
REQ-031 Preload mema[3]=0xAA, memb[5]=0x55; req0 with addra0=3, addrb0=5 -> gnt=01, done=01 3 cycles later, then mema[3]=0x55, memb[5]=0xAA, swap_cnt=1.
REQ-032 req0 and req1 held together from reset -> grant order 01,10,01,10; each done 3 cycles after its grant.
REQ-033 Same addresses in two consecutive swaps (mema[0]=0x11, memb[0]=0x22) -> after two swaps values restored, swap_cnt=2.
REQ-034 wr_en during READ -> no memory change, wr_err pulses 1 cycle; wr_en with req in IDLE -> write wins, grant next cycle.
REQ-035 rst asserted in WRITE cycle -> busy=0 and done=0 immediately, swap_cnt unchanged at 0, next req granted to requester 0.
REQ-036 256 swaps -> swap_cnt wraps to 0; rd port read of memb[5] every cycle tracks swap updates one cycle after the write.
